axi3_sink_gen: RTL and testbench
================================

Name: axi3_sink_gen

Overview:
- Parametrised AXI3 slave sink for the throughput cosim. It absorbs write bursts and returns one B response per burst, in order, with the correct BID from an ID FIFO. It also answers read bursts with a deterministic address-derived data pattern.
- Read answering is a build option; with it off, reads hang.
- Sits at the end of a PL/PS AXI3 port as a bandwidth target. Beat and burst counters are exported for measurement.

Parameters:
C_AXI_ID_WIDTH, 1, ID width on all channels
C_AXI_ADDR_WIDTH, 32, address width
C_AXI_DATA_WIDTH, 32, data width (power of 2, 32..1024)
B_DEPTH_P, 16, outstanding B responses held (power of 2, >=2)
READ_EN_P, 1, 1 = serve reads; 0 = ARREADY/RVALID tied low, RRESP=2'b11
CNT_WIDTH_P, 32, width of statistics counters

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset; asynchronous, active-low
S_AXI_AW{VALID,ID,ADDR,LEN[3:0],SIZE[2:0],BURST,LOCK[1:0],CACHE,PROT,QOS}  in  per AXI3  write address; only VALID, ID, LEN used
S_AXI_AWREADY  out  1
S_AXI_W{VALID,ID,DATA,STRB,LAST}  in  per AXI3  write data; WID, WDATA, WSTRB ignored
S_AXI_WREADY  out  1
S_AXI_BVALID  out  1;  S_AXI_BREADY  in  1;  S_AXI_BID  out  C_AXI_ID_WIDTH;  S_AXI_BRESP  out  2
S_AXI_AR{VALID,ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,QOS}  in  per AXI3  read address; VALID, ID, ADDR, LEN, SIZE used
S_AXI_ARREADY  out  1
S_AXI_RVALID  out  1;  S_AXI_RREADY  in  1;  S_AXI_RID  out  ID;  S_AXI_RDATA  out  DATA;  S_AXI_RLAST  out  1;  S_AXI_RRESP  out  2
wbeats_o  out  CNT_WIDTH_P  accepted W beats, wraps
wbursts_o  out  CNT_WIDTH_P  B entries pushed, wraps
rbeats_o  out  CNT_WIDTH_P  R beats handed off, wraps

Behaviour:
- Reset (async assert, sync deassert inside S_AXI_ACLK domain): write FSM=W_IDLE, read FSM=R_IDLE, B FIFO empty, counters 0. All VALID/READY/LAST outputs 0; BID/RID/RDATA 0; BRESP=0. RRESP=0, or 2'b11 if READ_EN_P=0. Reset mid-burst discards all in-flight bursts and pending B entries.
- Write FSM:
  - W_IDLE: AWREADY = (B FIFO not full). WREADY=0.
  - On AW handshake, latch AWID and AWLEN, clear beat count and error flag, go to W_DATA.
  - W_DATA: AWREADY=0, WREADY=1. Each W handshake increments beat and wbeats_o.
  - Burst ends on the handshake where WLAST=1 or beat==AWLEN, whichever comes first.
  - Error if WLAST and beat disagree on the end: early WLAST, or missing WLAST at beat==AWLEN. Ending beat pushes {AWID, error?2'b10:2'b00} to the B FIFO, increments wbursts_o, returns to W_IDLE.
  - AW-to-first-WREADY latency 1 cycle. Throughput 1 beat/cycle in W_DATA, 1 idle cycle between bursts.
- W beats never accepted before their AW; WVALID alone in W_IDLE stalls.
- B channel: BVALID = FIFO non-empty; BID/BRESP = head entry, registered FIFO storage. Pop on BVALID&BREADY. Order = burst completion order.
- FIFO full/empty rules:
  - Fullness for AWREADY is evaluated before any same-cycle pop (conservative; no combinational BREADY->AWREADY path).
  - Simultaneous push and pop legal at any non-full occupancy; occupancy unchanged.
  - Pointers wrap mod B_DEPTH_P. Occupancy counter width clog2(B_DEPTH_P)+1.
  - B_DEPTH_P bursts completed with BREADY=0: AWREADY stays low until one pop.
- Read FSM (READ_EN_P=1):
  - R_IDLE: ARREADY=1, RVALID=0. On AR handshake, latch ARID, ARADDR, ARLEN, ARSIZE; beat=0; go to R_DATA.
  - R_DATA: ARREADY=0, RVALID=1, RID=ARID, RRESP=2'b00, RLAST=(beat==ARLEN).
  - RDATA = ARADDR + (beat << ARSIZE), computed in C_AXI_ADDR_WIDTH then zero-extended/truncated to C_AXI_DATA_WIDTH.
  - Outputs held stable while RVALID & !RREADY. On handshake, beat++ and rbeats_o++. On handshake with RLAST, go to R_IDLE.
  - Read and write paths independent; both may be active the same cycle.
- READ_EN_P=0: ARREADY=0, RVALID=0, RLAST=0, RRESP=2'b11, rbeats_o=0 constant.
- Counters increment by 1 and wrap at 2^CNT_WIDTH_P.
- Unused inputs (BURST, LOCK, CACHE, PROT, QOS, WID, WSTRB, WDATA) have no effect.

Test Plan:
- Single write AWID=1, AWLEN=3, WLAST on 4th beat, BREADY=1 -> WREADY exactly 4 cycles; BVALID one cycle later with BID=1, BRESP=00; wbeats_o=4, wbursts_o=1.
- 3 back-to-back bursts IDs 0,1,0 (C_AXI_ID_WIDTH=1), BREADY=0 until done -> 3 B entries; on BREADY=1, BIDs 0,1,0 in order, BRESP=00 each.
- BREADY=0, 16 single-beat bursts with B_DEPTH_P=16 -> AWREADY low after 16th push. One B pop -> AWREADY high the following cycle. 17th burst accepted.
- AWLEN=3 with WLAST on beat 1 -> burst ends after 2 beats, BRESP=10. AWLEN=1 with no WLAST -> ends after 2 beats, BRESP=10.
- AR ARID=1, ARADDR=0x100, ARLEN=3, ARSIZE=2, RREADY toggling 1/0 -> RDATA 0x100, 0x104, 0x108, 0x10C. RLAST only on the last beat, data stable under stall, rbeats_o=4.
- Assert ARESETN low mid-read and with 5 pending B entries -> next cycle RVALID=0, BVALID=0, counters 0. After release, a new write burst completes normally.

Source files
------------

// File: rtl/axi3_sink_gen.sv
// AXI3 slave sink used as a bandwidth target. Write bursts are absorbed and
// answered with one B response each, in completion order, from a small FIFO.
// Reads are optionally answered with address-derived data. Beat and burst
// counters are exported for throughput measurement.
module axi3_sink_gen #(
  parameter int C_AXI_ID_WIDTH   = 1,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int B_DEPTH_P        = 16,
  parameter int READ_EN_P        = 1,
  parameter int CNT_WIDTH_P      = 32
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          S_AXI_AWVALID,
  input  logic [C_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [3:0]                    S_AXI_AWLEN,
  input  logic [2:0]                    S_AXI_AWSIZE,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic [1:0]                    S_AXI_AWLOCK,
  input  logic [3:0]                    S_AXI_AWCACHE,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic [3:0]                    S_AXI_AWQOS,
  output logic                          S_AXI_AWREADY,
  input  logic                          S_AXI_WVALID,
  input  logic [C_AXI_ID_WIDTH-1:0]     S_AXI_WID,
  input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  output logic                          S_AXI_WREADY,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  output logic [C_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  input  logic                          S_AXI_ARVALID,
  input  logic [C_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [3:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic [1:0]                    S_AXI_ARLOCK,
  input  logic [3:0]                    S_AXI_ARCACHE,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic [3:0]                    S_AXI_ARQOS,
  output logic                          S_AXI_ARREADY,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [C_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic                          S_AXI_RLAST,
  output logic [1:0]                    S_AXI_RRESP,
  output logic [CNT_WIDTH_P-1:0]        wbeats_o,
  output logic [CNT_WIDTH_P-1:0]        wbursts_o,
  output logic [CNT_WIDTH_P-1:0]        rbeats_o
);

  localparam int PTR_W = $clog2(B_DEPTH_P);
  localparam int OCC_W = PTR_W + 1;
  localparam int BENT_W = C_AXI_ID_WIDTH + 2;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_DATA = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [1:0] rst_sync_q;
  logic       rst_int_n;
  logic       run_q;

  logic [0:0]                w_state_q, w_state_d;
  logic [C_AXI_ID_WIDTH-1:0] w_id_q, w_id_d;
  logic [3:0]                w_len_q, w_len_d;
  logic [3:0]                w_beat_q, w_beat_d;
  logic [CNT_WIDTH_P-1:0]    wbeats_q, wbeats_d;
  logic [CNT_WIDTH_P-1:0]    wbursts_q, wbursts_d;

  logic aw_hs;
  logic w_hs;
  logic w_at_len;
  logic w_end;
  logic w_err;

  logic [BENT_W-1:0] b_mem_q [B_DEPTH_P];
  logic [PTR_W-1:0]  b_wr_ptr_q, b_wr_ptr_d;
  logic [PTR_W-1:0]  b_rd_ptr_q, b_rd_ptr_d;
  logic [OCC_W-1:0]  b_count_q, b_count_d;
  logic [BENT_W-1:0] b_push_entry;
  logic [BENT_W-1:0] b_head;
  logic              b_push;
  logic              b_pop;
  logic              b_full;

  logic unused_ok;

  // Reset asserts asynchronously but is released only on a clock edge, so
  // every flop below leaves reset in the same cycle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Holds the READY outputs low until the cycle after reset is released.
  always_ff @(posedge S_AXI_ACLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign b_full   = (b_count_q == OCC_W'(B_DEPTH_P));
  assign S_AXI_AWREADY = run_q && (w_state_q == W_IDLE) && !b_full;
  assign S_AXI_WREADY  = (w_state_q == W_DATA);
  assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
  assign w_at_len = (w_beat_q == w_len_q);
  assign w_end    = w_hs && (S_AXI_WLAST || w_at_len);
  assign w_err    = S_AXI_WLAST ^ w_at_len;

  // Write burst tracking: latch the AW, count beats, finish on WLAST or on
  // the AWLEN-th beat, whichever arrives first.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    wbeats_d  = wbeats_q;
    wbursts_d = wbursts_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          w_state_d = W_DATA;
          w_id_d    = S_AXI_AWID;
          w_len_d   = S_AXI_AWLEN;
          w_beat_d  = 4'd0;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          w_beat_d = w_beat_q + 4'd1;
          wbeats_d = wbeats_q + CNT_WIDTH_P'(1);
          if (w_end) begin
            wbursts_d = wbursts_q + CNT_WIDTH_P'(1);
            w_state_d = W_IDLE;
          end
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Write-side state registers.
  always_ff @(posedge S_AXI_ACLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      wbeats_q  <= '0;
      wbursts_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      wbeats_q  <= wbeats_d;
      wbursts_q <= wbursts_d;
    end
  end

  assign b_push       = w_end;
  assign b_push_entry = {w_id_q, (w_err ? 2'b10 : 2'b00)};
  assign b_pop        = S_AXI_BVALID && S_AXI_BREADY;

  // B FIFO pointer and occupancy update; a push cannot coincide with a full
  // FIFO because AW is only accepted while there is room.
  always_comb begin
    b_wr_ptr_d = b_wr_ptr_q;
    b_rd_ptr_d = b_rd_ptr_q;
    b_count_d  = b_count_q;
    if (b_push) begin
      b_wr_ptr_d = b_wr_ptr_q + PTR_W'(1);
    end
    if (b_pop) begin
      b_rd_ptr_d = b_rd_ptr_q + PTR_W'(1);
    end
    case ({b_push, b_pop})
      2'b10:   b_count_d = b_count_q + OCC_W'(1);
      2'b01:   b_count_d = b_count_q - OCC_W'(1);
      default: b_count_d = b_count_q;
    endcase
  end

  // B FIFO storage and pointers; reset drops every pending response.
  always_ff @(posedge S_AXI_ACLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < B_DEPTH_P; i++) begin
        b_mem_q[i] <= '0;
      end
      b_wr_ptr_q <= '0;
      b_rd_ptr_q <= '0;
      b_count_q  <= '0;
    end else begin
      if (b_push) begin
        b_mem_q[b_wr_ptr_q] <= b_push_entry;
      end
      b_wr_ptr_q <= b_wr_ptr_d;
      b_rd_ptr_q <= b_rd_ptr_d;
      b_count_q  <= b_count_d;
    end
  end

  assign b_head       = b_mem_q[b_rd_ptr_q];
  assign S_AXI_BVALID = (b_count_q != '0);
  assign S_AXI_BID    = S_AXI_BVALID ? b_head[BENT_W-1:2] : '0;
  assign S_AXI_BRESP  = S_AXI_BVALID ? b_head[1:0] : 2'b00;

  assign wbeats_o  = wbeats_q;
  assign wbursts_o = wbursts_q;

  generate
    if (READ_EN_P != 0) begin : g_read
      logic [0:0]                  r_state_q, r_state_d;
      logic [C_AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
      logic [C_AXI_ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
      logic [3:0]                  r_len_q, r_len_d;
      logic [2:0]                  r_size_q, r_size_d;
      logic [3:0]                  r_beat_q, r_beat_d;
      logic [CNT_WIDTH_P-1:0]      rbeats_q, rbeats_d;
      logic [C_AXI_ADDR_WIDTH-1:0] r_offset;
      logic [C_AXI_ADDR_WIDTH-1:0] r_word;
      logic                        ar_hs;
      logic                        r_hs;
      logic                        r_active;

      assign r_active      = (r_state_q == R_DATA);
      assign S_AXI_ARREADY = run_q && (r_state_q == R_IDLE);
      assign S_AXI_RVALID  = r_active;
      assign S_AXI_RLAST   = r_active && (r_beat_q == r_len_q);
      assign S_AXI_RRESP   = 2'b00;
      assign S_AXI_RID     = r_active ? r_id_q : '0;
      assign r_offset      = C_AXI_ADDR_WIDTH'(r_beat_q) << r_size_q;
      assign r_word        = r_addr_q + r_offset;
      assign S_AXI_RDATA   = r_active ? C_AXI_DATA_WIDTH'(r_word) : '0;
      assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
      assign r_hs          = S_AXI_RVALID && S_AXI_RREADY;
      assign rbeats_o      = rbeats_q;

      // Read burst sequencing: latch the AR, then present one beat at a
      // time, advancing only when the master takes it.
      always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_beat_d  = r_beat_q;
        rbeats_d  = rbeats_q;
        case (r_state_q)
          R_IDLE: begin
            if (ar_hs) begin
              r_state_d = R_DATA;
              r_id_d    = S_AXI_ARID;
              r_addr_d  = S_AXI_ARADDR;
              r_len_d   = S_AXI_ARLEN;
              r_size_d  = S_AXI_ARSIZE;
              r_beat_d  = 4'd0;
            end
          end
          R_DATA: begin
            if (r_hs) begin
              r_beat_d = r_beat_q + 4'd1;
              rbeats_d = rbeats_q + CNT_WIDTH_P'(1);
              if (S_AXI_RLAST) begin
                r_state_d = R_IDLE;
              end
            end
          end
          default: begin
            r_state_d = R_IDLE;
          end
        endcase
      end

      // Read-side state registers.
      always_ff @(posedge S_AXI_ACLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
          r_state_q <= R_IDLE;
          r_id_q    <= '0;
          r_addr_q  <= '0;
          r_len_q   <= '0;
          r_size_q  <= '0;
          r_beat_q  <= '0;
          rbeats_q  <= '0;
        end else begin
          r_state_q <= r_state_d;
          r_id_q    <= r_id_d;
          r_addr_q  <= r_addr_d;
          r_len_q   <= r_len_d;
          r_size_q  <= r_size_d;
          r_beat_q  <= r_beat_d;
          rbeats_q  <= rbeats_d;
        end
      end
    end else begin : g_noread
      logic unused_rd_ok;

      assign S_AXI_ARREADY = 1'b0;
      assign S_AXI_RVALID  = 1'b0;
      assign S_AXI_RLAST   = 1'b0;
      assign S_AXI_RRESP   = 2'b11;
      assign S_AXI_RID     = '0;
      assign S_AXI_RDATA   = '0;
      assign rbeats_o      = '0;
      assign unused_rd_ok  = ^{S_AXI_ARVALID, S_AXI_ARID, S_AXI_ARADDR,
                               S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_RREADY};
    end
  endgenerate

  assign unused_ok = ^{S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK,
                       S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_WID,
                       S_AXI_WDATA, S_AXI_WSTRB, S_AXI_ARBURST, S_AXI_ARLOCK,
                       S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS};

endmodule

// File: tb/tb_axi3_sink_gen.sv
// Directed bench for axi3_sink_gen: write bursts with good and bad WLAST,
// B FIFO fill and drain, a stalled read burst and a mid-traffic reset.
module tb_axi3_sink_gen;

  localparam int ID_W  = 1;
  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int BDEP  = 16;
  localparam int CNT_W = 32;

  logic               clk;
  logic               rst_n;
  logic               awvalid;
  logic [ID_W-1:0]    awid;
  logic [ADR_W-1:0]   awaddr;
  logic [3:0]         awlen;
  logic [2:0]         awsize;
  logic [1:0]         awburst;
  logic [1:0]         awlock;
  logic [3:0]         awcache;
  logic [2:0]         awprot;
  logic [3:0]         awqos;
  logic               awready;
  logic               wvalid;
  logic [ID_W-1:0]    wid;
  logic [DAT_W-1:0]   wdata;
  logic [DAT_W/8-1:0] wstrb;
  logic               wlast;
  logic               wready;
  logic               bvalid;
  logic               bready;
  logic [ID_W-1:0]    bid;
  logic [1:0]         bresp;
  logic               arvalid;
  logic [ID_W-1:0]    arid;
  logic [ADR_W-1:0]   araddr;
  logic [3:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic [1:0]         arlock;
  logic [3:0]         arcache;
  logic [2:0]         arprot;
  logic [3:0]         arqos;
  logic               arready;
  logic               rvalid;
  logic               rready;
  logic [ID_W-1:0]    rid;
  logic [DAT_W-1:0]   rdata;
  logic               rlast;
  logic [1:0]         rresp;
  logic [CNT_W-1:0]   wbeats;
  logic [CNT_W-1:0]   wbursts;
  logic [CNT_W-1:0]   rbeats;

  int          assertCount;
  int          failCount;
  int          wreadyCycles;
  int unsigned wbeatsExp;
  int unsigned wburstsExp;
  int unsigned rbeatsExp;

  logic [2:0]       bq[$];
  logic [33:0]      rq[$];
  logic             holdValid;
  logic [DAT_W-1:0] holdData;
  logic             holdLast;

  axi3_sink_gen #(
    .C_AXI_ID_WIDTH(ID_W), .C_AXI_ADDR_WIDTH(ADR_W), .C_AXI_DATA_WIDTH(DAT_W),
    .B_DEPTH_P(BDEP), .READ_EN_P(1), .CNT_WIDTH_P(CNT_W)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr),
    .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
    .S_AXI_AWLOCK(awlock), .S_AXI_AWCACHE(awcache), .S_AXI_AWPROT(awprot),
    .S_AXI_AWQOS(awqos), .S_AXI_AWREADY(awready),
    .S_AXI_WVALID(wvalid), .S_AXI_WID(wid), .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WREADY(wready),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BID(bid),
    .S_AXI_BRESP(bresp),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr),
    .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
    .S_AXI_ARLOCK(arlock), .S_AXI_ARCACHE(arcache), .S_AXI_ARPROT(arprot),
    .S_AXI_ARQOS(arqos), .S_AXI_ARREADY(arready),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RID(rid),
    .S_AXI_RDATA(rdata), .S_AXI_RLAST(rlast), .S_AXI_RRESP(rresp),
    .wbeats_o(wbeats), .wbursts_o(wbursts), .rbeats_o(rbeats)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Looks at the channels just before the coming edge: handshakes pop the
  // scoreboard, stalled R beats must not change.
  task automatic monitorOutputs();
    logic [2:0]  be;
    logic [33:0] re;
    if (wready) wreadyCycles++;
    if (bvalid && bready) begin
      if (bq.size() == 0) begin
        checkOutput("b_unexpected", 64'(1), 64'(0));
      end else begin
        be = bq.pop_front();
        checkOutput("b_id", 64'(bid), 64'(be[2]));
        checkOutput("b_resp", 64'(bresp), 64'(be[1:0]));
      end
    end
    if (holdValid && rvalid) begin
      checkOutput("r_stall_data", 64'(rdata), 64'(holdData));
      checkOutput("r_stall_last", 64'(rlast), 64'(holdLast));
    end
    if (rvalid && rready) begin
      if (rq.size() == 0) begin
        checkOutput("r_unexpected", 64'(1), 64'(0));
      end else begin
        re = rq.pop_front();
        checkOutput("r_id", 64'(rid), 64'(re[33]));
        checkOutput("r_last", 64'(rlast), 64'(re[32]));
        checkOutput("r_data", 64'(rdata), 64'(re[31:0]));
        checkOutput("r_resp", 64'(rresp), 64'(0));
        rbeatsExp++;
      end
    end
    holdValid = rvalid && !rready;
    holdData  = rdata;
    holdLast  = rlast;
  endtask

  // Advance one clock; inputs change 1 ns after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitorOutputs();
    @(posedge clk);
    #1;
  endtask

  // One write burst; lastAt is the beat index carrying WLAST (-1 = never).
  task automatic applyStimulus(input logic [ID_W-1:0] id, input int len, input int lastAt);
    int nbeats;
    int n;
    logic err;
    nbeats = (lastAt >= 0 && lastAt < len) ? lastAt + 1 : len + 1;
    err    = (lastAt != len);
    bq.push_back({id, (err ? 2'b10 : 2'b00)});
    awvalid = 1'b1;
    awid    = id;
    awlen   = 4'(len);
    awaddr  = $urandom;
    awburst = 2'($urandom);
    n = 0;
    while (!awready && n < 50) begin
      tick();
      n++;
    end
    if (!awready) checkOutput("aw_timeout", 64'(0), 64'(1));
    tick();
    awvalid = 1'b0;
    checkOutput("aw_to_wready", 64'(wready), 64'(1));
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1;
      wlast  = (i == lastAt);
      wdata  = $urandom;
      wstrb  = 4'($urandom);
      wid    = 1'($urandom);
      n = 0;
      while (!wready && n < 50) begin
        tick();
        n++;
      end
      if (!wready) checkOutput("w_timeout", 64'(0), 64'(1));
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    checkOutput("bvalid_after_last", 64'(bvalid), 64'(1));
    wbeatsExp  += nbeats;
    wburstsExp++;
  endtask

  // Issue one AR and queue the expected beats.
  task automatic startRead(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input int len, input int size);
    int n;
    for (int i = 0; i <= len; i++) begin
      rq.push_back({id, (i == len), 32'(addr + (32'(i) << size))});
    end
    arvalid = 1'b1;
    arid    = id;
    araddr  = addr;
    arlen   = 4'(len);
    arsize  = 3'(size);
    n = 0;
    while (!arready && n < 50) begin
      tick();
      n++;
    end
    if (!arready) checkOutput("ar_timeout", 64'(0), 64'(1));
    tick();
    arvalid = 1'b0;
  endtask

  initial begin
    assertCount = 0; failCount = 0; wreadyCycles = 0;
    wbeatsExp = 0; wburstsExp = 0; rbeatsExp = 0;
    holdValid = 1'b0; holdData = '0; holdLast = 1'b0;
    rst_n = 1'b0;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 2'b01;
    awlock = 0; awcache = 0; awprot = 0; awqos = 0;
    wvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 2'b01;
    arlock = 0; arcache = 0; arprot = 0; arqos = 0; rready = 0;

    repeat (3) tick();
    checkOutput("rst_awready", 64'(awready), 64'(0));
    checkOutput("rst_wready", 64'(wready), 64'(0));
    checkOutput("rst_bvalid", 64'(bvalid), 64'(0));
    checkOutput("rst_bid", 64'(bid), 64'(0));
    checkOutput("rst_bresp", 64'(bresp), 64'(0));
    checkOutput("rst_arready", 64'(arready), 64'(0));
    checkOutput("rst_rvalid", 64'(rvalid), 64'(0));
    checkOutput("rst_rlast", 64'(rlast), 64'(0));
    checkOutput("rst_rid", 64'(rid), 64'(0));
    checkOutput("rst_rdata", 64'(rdata), 64'(0));
    checkOutput("rst_rresp", 64'(rresp), 64'(0));
    checkOutput("rst_wbeats", 64'(wbeats), 64'(0));
    checkOutput("rst_wbursts", 64'(wbursts), 64'(0));
    checkOutput("rst_rbeats", 64'(rbeats), 64'(0));
    rst_n = 1'b1;
    repeat (5) tick();
    checkOutput("run_awready", 64'(awready), 64'(1));
    checkOutput("run_arready", 64'(arready), 64'(1));

    $display("[TB] single write burst");
    bready = 1'b1;
    wreadyCycles = 0;
    applyStimulus(1'b1, 3, 3);
    repeat (3) tick();
    checkOutput("t1_wready_cycles", 64'(wreadyCycles), 64'(4));
    checkOutput("t1_wbeats", 64'(wbeats), 64'(wbeatsExp));
    checkOutput("t1_wbursts", 64'(wbursts), 64'(wburstsExp));
    checkOutput("t1_bq_empty", 64'(bq.size()), 64'(0));

    $display("[TB] three bursts held then drained in order");
    bready = 1'b0;
    applyStimulus(1'b0, 1, 1);
    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b0, 2, 2);
    tick();
    checkOutput("t2_bvalid_held", 64'(bvalid), 64'(1));
    checkOutput("t2_pending", 64'(bq.size()), 64'(3));
    bready = 1'b1;
    repeat (5) tick();
    checkOutput("t2_bq_empty", 64'(bq.size()), 64'(0));
    checkOutput("t2_bvalid_low", 64'(bvalid), 64'(0));

    $display("[TB] B FIFO full back-pressure");
    bready = 1'b0;
    for (int k = 0; k < BDEP; k++) applyStimulus(1'(k), 0, 0);
    checkOutput("t3_full_awready", 64'(awready), 64'(0));
    repeat (2) tick();
    checkOutput("t3_full_awready_hold", 64'(awready), 64'(0));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checkOutput("t3_after_pop_awready", 64'(awready), 64'(1));
    applyStimulus(1'b1, 0, 0);
    checkOutput("t3_wbursts", 64'(wbursts), 64'(wburstsExp));
    bready = 1'b1;
    repeat (20) tick();
    checkOutput("t3_bq_empty", 64'(bq.size()), 64'(0));
    checkOutput("t3_bvalid_low", 64'(bvalid), 64'(0));

    $display("[TB] WLAST disagreement bursts");
    applyStimulus(1'b0, 3, 1);
    applyStimulus(1'b1, 1, -1);
    repeat (3) tick();
    checkOutput("t4_bq_empty", 64'(bq.size()), 64'(0));
    checkOutput("t4_wbeats", 64'(wbeats), 64'(wbeatsExp));
    checkOutput("t4_wbursts", 64'(wbursts), 64'(wburstsExp));

    $display("[TB] read burst with RREADY toggling");
    rready = 1'b0;
    startRead(1'b1, 32'h100, 3, 2);
    for (int c = 0; c < 40 && rq.size() != 0; c++) begin
      rready = ~rready;
      tick();
    end
    rready = 1'b0;
    checkOutput("t5_rq_empty", 64'(rq.size()), 64'(0));
    tick();
    checkOutput("t5_rvalid_low", 64'(rvalid), 64'(0));
    checkOutput("t5_rbeats", 64'(rbeats), 64'(rbeatsExp));
    checkOutput("t5_rbeats_abs", 64'(rbeats), 64'(4));

    $display("[TB] reset with traffic in flight");
    bready = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus(1'(k), 0, 0);
    rready = 1'b1;
    startRead(1'b0, 32'h40, 7, 3);
    repeat (2) tick();
    rready = 1'b0;
    tick();
    rst_n = 1'b0;
    bq.delete();
    rq.delete();
    tick();
    checkOutput("t6_rvalid", 64'(rvalid), 64'(0));
    checkOutput("t6_bvalid", 64'(bvalid), 64'(0));
    checkOutput("t6_wbeats", 64'(wbeats), 64'(0));
    checkOutput("t6_wbursts", 64'(wbursts), 64'(0));
    checkOutput("t6_rbeats", 64'(rbeats), 64'(0));
    checkOutput("t6_awready", 64'(awready), 64'(0));
    rst_n = 1'b1;
    wbeatsExp = 0; wburstsExp = 0; rbeatsExp = 0;
    repeat (5) tick();
    bready = 1'b1;
    applyStimulus(1'b1, 2, 2);
    repeat (3) tick();
    checkOutput("t6_post_bq_empty", 64'(bq.size()), 64'(0));
    checkOutput("t6_post_wbeats", 64'(wbeats), 64'(3));
    checkOutput("t6_post_wbursts", 64'(wbursts), 64'(1));
    checkOutput("t6_post_bvalid", 64'(bvalid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
